// File: rtl/alu_arbiter_if.sv
// Requester/response handshake and ALU hookup bundle for alu_arbiter.
// slave = arbiter side, master = requesters plus the external ALU.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid;
  logic             req1_valid;
  logic             req0_ready;
  logic             req1_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req0_b;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req0_op;
  logic [2:0]       req1_op;
  logic             resp0_valid;
  logic             resp1_valid;
  logic             resp0_ready;
  logic             resp1_ready;
  logic [WIDTH-1:0] resp_data;
  logic             resp_err;
  logic [WIDTH-1:0] alu_srcA;
  logic [WIDTH-1:0] alu_srcB;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_result;

  modport slave (
    input  req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b, req0_op, req1_op,
    output req0_ready, req1_ready,
    output resp0_valid, resp1_valid, resp_data, resp_err,
    input  resp0_ready, resp1_ready,
    output alu_srcA, alu_srcB, alu_ctrl,
    input  alu_result
  );

  modport master (
    output req0_valid, req1_valid, req0_a, req1_a, req0_b, req1_b, req0_op, req1_op,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp1_valid, resp_data, resp_err,
    output resp0_ready, resp1_ready,
    input  alu_srcA, alu_srcB, alu_ctrl,
    output alu_result
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one external ALU between two requesters, one op in flight.
// Optional illegal-op trapping (ops 100/110/111) enabled by defining ALU_ARB_OPCHECK_EN.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic             r_last_grant;
  logic             r_gnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_err;

  logic             w_any_valid;
  logic             w_grant;
  logic             w_accept;
  logic             w_consume;
  logic             w_illegal;

  // Tie goes to whoever was not served last; a lone request always wins.
  assign w_any_valid = bus.req0_valid | bus.req1_valid;
  assign w_grant     = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
  assign w_accept    = (r_state == S_IDLE) && w_any_valid;
  assign w_consume   = (r_state == S_RESP) && (r_gnt ? bus.resp1_ready : bus.resp0_ready);

`ifdef ALU_ARB_OPCHECK_EN
  assign w_illegal = (r_op == 3'b100) || (r_op == 3'b110) || (r_op == 3'b111);
`else
  assign w_illegal = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process evaluation order.
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves the
    // signal unassigned, which would infer a latch.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_any_valid) w_next_state = S_ISSUE;
      S_ISSUE: w_next_state = S_RESP;
      S_RESP:  if (w_consume) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these are a handful of flops, not a memory array, so all get an
      // explicit reset value; an aborted op leaves nothing behind.
      r_last_grant <= 1'b1;
      r_gnt        <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= 3'b000;
      r_result     <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_gnt        <= w_grant;
        r_last_grant <= w_grant;
        r_a          <= w_grant ? bus.req1_a  : bus.req0_a;
        r_b          <= w_grant ? bus.req1_b  : bus.req0_b;
        r_op         <= w_grant ? bus.req1_op : bus.req0_op;
      end
      if (r_state == S_ISSUE) begin
        r_result <= w_illegal ? '0 : bus.alu_result;
        r_err    <= w_illegal;
      end
    end
  end

  assign bus.req0_ready  = w_accept && !w_grant;
  assign bus.req1_ready  = w_accept &&  w_grant;
  assign bus.resp0_valid = (r_state == S_RESP) && !r_gnt;
  assign bus.resp1_valid = (r_state == S_RESP) &&  r_gnt;
  assign bus.resp_data   = r_result;
  assign bus.resp_err    = r_err;

  // Illegal ops run the ALU as a harmless add so nothing downstream sees them.
  assign bus.alu_srcA    = r_a;
  assign bus.alu_srcB    = r_b;
  assign bus.alu_ctrl    = w_illegal ? 3'b000 : r_op;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU, accept-time scoreboard,
// one task per scenario.
module tb_alu_arbiter;

  localparam int WIDTH = 32;

  typedef struct {
    bit          id;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cycle    = 0;

  exp_t        sb[$];
  int          grant_log[$];
  logic [31:0] resp_log[$];

  alu_arbiter_if #(.WIDTH(WIDTH)) bus ();

  alu_arbiter #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return {31'b0, ($signed(a) < $signed(b))};
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic exp_t ref_model(bit id, logic [31:0] a, logic [31:0] b, logic [2:0] op);
    exp_t e;
    e.id   = id;
    e.data = alu_fn(a, b, op);
    e.err  = 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
    if (op == 3'b100 || op == 3'b110 || op == 3'b111) begin
      e.data = 32'h0;
      e.err  = 1'b1;
    end
`endif
    return e;
  endfunction

  assign bus.alu_result = alu_fn(bus.alu_srcA, bus.alu_srcB, bus.alu_ctrl);

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation still running at 1ms, expected completion");
    $fatal(1, "watchdog");
  end

  // Accept-side pushes and response-side pops/compares.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req0_valid && bus.req0_ready) begin
        sb.push_back(ref_model(1'b0, bus.req0_a, bus.req0_b, bus.req0_op));
        grant_log.push_back(0);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        sb.push_back(ref_model(1'b1, bus.req1_a, bus.req1_b, bus.req1_op));
        grant_log.push_back(1);
      end
      if (bus.resp0_valid && bus.resp1_valid) begin
        n_checks++;
        $display("FAIL resp_onehot: got both resp valids high, expected at most one");
      end
      for (int ch = 0; ch < 2; ch++) begin
        if ((ch == 0 && bus.resp0_valid && bus.resp0_ready) ||
            (ch == 1 && bus.resp1_valid && bus.resp1_ready)) begin
          n_checks++;
          resp_log.push_back(bus.resp_data);
          if (sb.size() == 0) begin
            $display("FAIL sb_unexpected: got response on ch%0d data=%h, expected none", ch, bus.resp_data);
          end else begin
            exp_t e;
            e = sb.pop_front();
            if (e.id != ch[0] || bus.resp_data !== e.data || bus.resp_err !== e.err)
              $display("FAIL sb_resp: got ch%0d data=%h err=%b, expected ch%0d data=%h err=%b",
                       ch, bus.resp_data, bus.resp_err, e.id, e.data, e.err);
            else n_pass++;
          end
        end
      end
    end
  end

  task automatic do_req(input bit id, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] op, input bit hold, output int acc);
    bit ok;
    ok  = 1'b0;
    acc = -1;
    if (!id) begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1;
    end
    #1;
    for (int i = 0; i < 30; i++) begin
      if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!ok) $display("FAIL req%0d_accept: got no ready within 30 cycles, expected accept", id);
    else n_pass++;
    if (ok) begin
      @(posedge clk); #1;
      acc = cycle;
    end
    if (!hold) begin
      if (!id) bus.req0_valid = 1'b0;
      else     bus.req1_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (sb.size() == 0 && !bus.resp0_valid && !bus.resp1_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_checks++;
    if (!ok) $display("FAIL %s_drain: got %0d pending responses, expected 0", name, sb.size());
    else n_pass++;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #2;
    sb.delete();
    grant_log.delete();
    resp_log.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #13;
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, bus.resp_err} !== 5'b0)
      $display("FAIL reset_flags: got %b, expected 00000",
               {bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, bus.resp_err});
    else n_pass++;
    n_checks++;
    if (bus.resp_data !== 32'h0) $display("FAIL reset_data: got %h, expected 0", bus.resp_data);
    else n_pass++;
    n_checks++;
    if ({bus.alu_srcA, bus.alu_srcB, bus.alu_ctrl} !== 67'h0)
      $display("FAIL reset_alu: got a=%h b=%h ctrl=%b, expected zeros", bus.alu_srcA, bus.alu_srcB, bus.alu_ctrl);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    resp_log.delete();
    bus.req0_a = 32'd10; bus.req0_b = 32'd5; bus.req0_op = 3'b000; bus.req0_valid = 1'b1;
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0)
      $display("FAIL single_ready: got r0=%b r1=%b, expected r0=1 r1=0", bus.req0_ready, bus.req1_ready);
    else n_pass++;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    n_checks++;
    if (bus.req0_ready !== 1'b0 || bus.resp0_valid !== 1'b0)
      $display("FAIL single_issue: got ready=%b resp0_valid=%b, expected 0 0", bus.req0_ready, bus.resp0_valid);
    else n_pass++;
    n_checks++;
    if (bus.alu_srcA !== 32'd10 || bus.alu_srcB !== 32'd5 || bus.alu_ctrl !== 3'b000)
      $display("FAIL single_alu_drive: got a=%0d b=%0d ctrl=%b, expected 10 5 000",
               bus.alu_srcA, bus.alu_srcB, bus.alu_ctrl);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (bus.resp0_valid !== 1'b1 || bus.resp1_valid !== 1'b0 || bus.resp_data !== 32'd15)
      $display("FAIL single_resp: got v0=%b v1=%b data=%0d, expected 1 0 15",
               bus.resp0_valid, bus.resp1_valid, bus.resp_data);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (bus.resp0_valid !== 1'b0) $display("FAIL single_consumed: got resp0_valid=%b, expected 0", bus.resp0_valid);
    else n_pass++;
    wait_drain("single");
  endtask

  task automatic test_back_to_back();
    int          c[4];
    logic [31:0] exp_data[4];
    exp_data = '{32'd5, 32'd0, 32'd15, 32'd1};
    resp_log.delete();
    do_req(1'b0, 32'd10, 32'd5,  3'b001, 1'b1, c[0]);
    do_req(1'b0, 32'd10, 32'd5,  3'b010, 1'b1, c[1]);
    do_req(1'b0, 32'd10, 32'd5,  3'b011, 1'b1, c[2]);
    do_req(1'b0, 32'd5,  32'd10, 3'b101, 1'b0, c[3]);
    wait_drain("b2b");
    for (int i = 1; i < 4; i++) begin
      n_checks++;
      if (c[i] - c[i-1] != 3) $display("FAIL b2b_period%0d: got %0d cycles, expected 3", i, c[i] - c[i-1]);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (resp_log.size() <= i) $display("FAIL b2b_data%0d: got no response, expected %0d", i, exp_data[i]);
      else if (resp_log[i] !== exp_data[i]) $display("FAIL b2b_data%0d: got %0d, expected %0d", i, resp_log[i], exp_data[i]);
      else n_pass++;
    end
  endtask

  task automatic test_fairness();
    int exp_g[4];
    logic [31:0] exp_d[4];
    exp_g = '{0, 1, 0, 1};
    exp_d = '{32'd15, 32'd5, 32'd15, 32'd5};
    apply_reset();
    bus.req0_a = 32'd10; bus.req0_b = 32'd5; bus.req0_op = 3'b000; bus.req0_valid = 1'b1;
    bus.req1_a = 32'd10; bus.req1_b = 32'd5; bus.req1_op = 3'b001; bus.req1_valid = 1'b1;
    for (int i = 0; i < 40 && grant_log.size() < 4; i++) begin
      @(posedge clk); #1;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_drain("fair");
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (grant_log.size() <= i) $display("FAIL fair_grant%0d: got no grant, expected %0d", i, exp_g[i]);
      else if (grant_log[i] != exp_g[i]) $display("FAIL fair_grant%0d: got %0d, expected %0d", i, grant_log[i], exp_g[i]);
      else n_pass++;
      n_checks++;
      if (resp_log.size() <= i) $display("FAIL fair_data%0d: got no response, expected %0d", i, exp_d[i]);
      else if (resp_log[i] !== exp_d[i]) $display("FAIL fair_data%0d: got %0d, expected %0d", i, resp_log[i], exp_d[i]);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    int acc;
    bus.resp1_ready = 1'b0;
    do_req(1'b1, 32'd10, 32'd5, 3'b011, 1'b0, acc);
    bus.req0_a = 32'd3; bus.req0_b = 32'd4; bus.req0_op = 3'b000; bus.req0_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (bus.resp1_valid !== 1'b1 || bus.resp_data !== 32'd15 || bus.req0_ready !== 1'b0)
        $display("FAIL stall_hold%0d: got v1=%b data=%0d r0=%b, expected 1 15 0",
                 i, bus.resp1_valid, bus.resp_data, bus.req0_ready);
      else n_pass++;
      @(posedge clk); #1;
    end
    bus.resp1_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.resp1_valid !== 1'b0 || bus.req0_ready !== 1'b1)
      $display("FAIL stall_resume: got v1=%b r0=%b, expected 0 1", bus.resp1_valid, bus.req0_ready);
    else n_pass++;
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    wait_drain("stall");
  endtask

  task automatic test_reset_mid_op();
    int acc;
    bit seen;
    do_req(1'b0, 32'd10, 32'd5, 3'b000, 1'b0, acc);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, bus.resp_err} !== 5'b0 ||
        bus.resp_data !== 32'h0)
      $display("FAIL midrst_resp: got flags=%b data=%h, expected 00000 0",
               {bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid, bus.resp_err}, bus.resp_data);
    else n_pass++;
    n_checks++;
    if ({bus.alu_srcA, bus.alu_srcB, bus.alu_ctrl} !== 67'h0)
      $display("FAIL midrst_alu: got a=%h b=%h ctrl=%b, expected zeros", bus.alu_srcA, bus.alu_srcB, bus.alu_ctrl);
    else n_pass++;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus.resp0_valid || bus.resp1_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen) $display("FAIL midrst_noresp: got a response after reset, expected none");
    else n_pass++;
  endtask

  task automatic test_illegal_op();
    int          acc;
    logic [2:0]  exp_ctrl;
    logic [31:0] exp_data;
    logic        exp_err;
`ifdef ALU_ARB_OPCHECK_EN
    exp_ctrl = 3'b000; exp_data = 32'h0;         exp_err = 1'b1;
`else
    exp_ctrl = 3'b111; exp_data = 32'hDEAD_BEEF; exp_err = 1'b0;
`endif
    do_req(1'b0, 32'd10, 32'd5, 3'b111, 1'b0, acc);
    n_checks++;
    if (bus.alu_ctrl !== exp_ctrl) $display("FAIL illegal_ctrl: got %b, expected %b", bus.alu_ctrl, exp_ctrl);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (bus.resp0_valid !== 1'b1 || bus.resp_err !== exp_err || bus.resp_data !== exp_data)
      $display("FAIL illegal_resp: got v0=%b err=%b data=%h, expected 1 %b %h",
               bus.resp0_valid, bus.resp_err, bus.resp_data, exp_err, exp_data);
    else n_pass++;
    wait_drain("illegal");
  endtask

  initial begin
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_fairness();
    test_stall();
    test_reset_mid_op();
    test_illegal_op();
    n_checks++;
    if (sb.size() != 0) $display("FAIL final_sb: got %0d outstanding, expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
